store_rmw_controller: RTL and testbench

- Sequencer that performs a complete store for sb/sh/sw in the multicycle datapath.
- For sub-word stores it reads the containing memory word into an internal data register, merges the B-register byte/halfword into the lane selected by addr[1:0], then writes the word back.
- Word stores skip the read. Misaligned or illegal stores raise a one-cycle exception flag and never write.
- Sits between the control unit (start/size) and the synchronous memory port.

---
 rtl/store_rmw_controller_if.sv | 25 ++
 rtl/store_rmw_controller.sv | 118 +++++++++++
 tb/tb_store_rmw_controller.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/store_rmw_controller_if.sv
// Control-unit and memory-port signals of the store read-modify-write sequencer.
// The master side is the environment (control unit plus memory); the slave side is the controller.
interface store_rmw_controller_if;
    logic        start;
    logic [1:0]  store_size;
    logic [31:0] addr;
    logic [31:0] b_out;
    logic [31:0] mem_rdata;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        misaligned;

    modport master (
        output start, store_size, addr, b_out, mem_rdata,
        input  mem_addr, mem_wr, mem_wdata, busy, done, misaligned
    );

    modport slave (
        input  start, store_size, addr, b_out, mem_rdata,
        output mem_addr, mem_wr, mem_wdata, busy, done, misaligned
    );
endinterface

// File: rtl/store_rmw_controller.sv
// Store sequencer for sb/sh/sw: sub-word stores read the containing word, merge the
// B-register lane and write it back; word stores write directly; bad requests flag and abort.
module store_rmw_controller #(
    parameter int READ_LATENCY = 1   // legal range 1..3
) (
    input logic                    clk,
    input logic                    reset,
    store_rmw_controller_if.slave  bus
);
    localparam int NUM_LANES = 4;
    localparam int VEC_W     = 8;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] RD_INIT = 2'(READ_LATENCY - 1);

    logic [2:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] b_q, b_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] mdr_q, mdr_d;
    logic [1:0]  rd_cnt_q, rd_cnt_d;
    logic        req_bad;

    logic [NUM_LANES-1:0][VEC_W-1:0] wdata;

    always_comb begin
        req_bad = (bus.store_size == 2'b11)
               || (bus.store_size == SZ_HALF && bus.addr[0])
               || (bus.store_size == SZ_WORD && bus.addr[1:0] != 2'b00);
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        b_d      = b_q;
        size_d   = size_q;
        mdr_d    = mdr_q;
        rd_cnt_d = rd_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    addr_d = bus.addr;
                    b_d    = bus.b_out;
                    size_d = bus.store_size;
                    if (req_bad) begin
                        state_d = S_ERR;
                    end else if (bus.store_size == SZ_WORD) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d  = S_READ;
                        rd_cnt_d = RD_INIT;
                    end
                end
            end
            S_READ: begin
                // rd_cnt==0 marks the cycle in which the memory word is valid
                if (rd_cnt_q == 2'd0) begin
                    mdr_d   = bus.mem_rdata;
                    state_d = S_WRITE;
                end else begin
                    rd_cnt_d = rd_cnt_q - 2'd1;
                end
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            b_q      <= '0;
            size_q   <= '0;
            mdr_q    <= '0;
            rd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            b_q      <= b_d;
            size_q   <= size_d;
            mdr_q    <= mdr_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    // Per-lane merge: a lane takes B-register data when the store covers it, else keeps mdr.
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic             sel;
        logic [VEC_W-1:0] src;

        assign sel = (size_q == SZ_WORD)
                   | ((size_q == SZ_HALF) & (addr_q[1] == 1'(l / 2)))
                   | ((size_q == SZ_BYTE) & (addr_q[1:0] == 2'(l)));
        assign src = (size_q == SZ_WORD) ? b_q[VEC_W*l +: VEC_W]
                   : (size_q == SZ_HALF) ? b_q[VEC_W*(l % 2) +: VEC_W]
                   :                       b_q[VEC_W-1:0];
        assign wdata[l] = sel ? src : mdr_q[VEC_W*l +: VEC_W];
    end

    assign bus.mem_addr   = {addr_q[31:2], 2'b00};
    assign bus.mem_wdata  = wdata;
    assign bus.mem_wr     = (state_q == S_WRITE);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = (state_q == S_DONE);
    assign bus.misaligned = (state_q == S_ERR);

endmodule

// File: tb/tb_store_rmw_controller.sv
// Scoreboard bench for store_rmw_controller: two instances (read latency 1 and 3),
// directed stores push expected write/done/error events that a negedge monitor pops.
module tb_store_rmw_controller;
    localparam int EV_WR   = 1;
    localparam int EV_DONE = 2;
    localparam int EV_ERR  = 3;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic [1:0] rst_n;
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;
    int         rc [2];
    ev_t        q0 [$];
    ev_t        q1 [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    store_rmw_controller_if ifa ();
    store_rmw_controller_if ifb ();

    store_rmw_controller #(.READ_LATENCY(1)) dut_a (.clk(clk), .reset(rst_n[0]), .bus(ifa));
    store_rmw_controller #(.READ_LATENCY(3)) dut_b (.clk(clk), .reset(rst_n[1]), .bus(ifb));

    // Memory model: data is valid only in the READ_LATENCY-th cycle of the read, junk otherwise.
    always @(posedge clk) begin
        rc[0] <= (ifa.busy && !ifa.mem_wr) ? rc[0] + 1 : 0;
        rc[1] <= (ifb.busy && !ifb.mem_wr) ? rc[1] + 1 : 0;
    end
    assign ifa.mem_rdata = (rc[0] == 0) ? 32'hAABBCCDD : 32'hBAD0BAD0;
    assign ifb.mem_rdata = (rc[1] == 2) ? 32'h11223344 : 32'hBAD0BAD0;

    logic [1:0]        wr_s, dn_s, ms_s, bz_s;
    logic [1:0][31:0]  ma_s, wd_s;
    assign wr_s = {ifb.mem_wr, ifa.mem_wr};
    assign dn_s = {ifb.done, ifa.done};
    assign ms_s = {ifb.misaligned, ifa.misaligned};
    assign bz_s = {ifb.busy, ifa.busy};
    assign ma_s = {ifb.mem_addr, ifa.mem_addr};
    assign wd_s = {ifb.mem_wdata, ifa.mem_wdata};

    task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int i, input int k, input logic [31:0] a, input logic [31:0] d, input int c);
        ev_t e;
        e.kind = k; e.addr = a; e.data = d; e.cyc = c;
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic chk(input int i, input int k);
        ev_t e;
        int  have;
        tests++;
        have = (i == 0) ? q0.size() : q1.size();
        if (have == 0) begin
            fails++;
            $display("FAIL inst%0d unexpected event: got kind %0d at cycle %0d, expected none", i, k, cyc);
        end else begin
            if (i == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            if (e.kind != k || e.cyc != cyc) begin
                fails++;
                $display("FAIL inst%0d event: got kind %0d cycle %0d, expected kind %0d cycle %0d",
                         i, k, cyc, e.kind, e.cyc);
            end
            if (k == EV_WR) begin
                tests++;
                if (ma_s[i] !== e.addr || wd_s[i] !== e.data) begin
                    fails++;
                    $display("FAIL inst%0d write: got addr %08h data %08h, expected addr %08h data %08h",
                             i, ma_s[i], wd_s[i], e.addr, e.data);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (wr_s[i]) chk(i, EV_WR);
            if (dn_s[i]) chk(i, EV_DONE);
            if (ms_s[i]) chk(i, EV_ERR);
        end
    end

    task automatic drv(input int i, input logic st, input logic [1:0] sz, input logic [31:0] ad, input logic [31:0] b);
        if (i == 0) begin
            ifa.start = st; ifa.store_size = sz; ifa.addr = ad; ifa.b_out = b;
        end else begin
            ifb.start = st; ifb.store_size = sz; ifb.addr = ad; ifb.b_out = b;
        end
    endtask

    // Issue one store at a negedge (cycle 0); optionally pulse start again in cycle pulse_k.
    task automatic store(input int i, input logic [1:0] sz, input logic [31:0] ad, input logic [31:0] b,
                         input logic err, input logic [31:0] exp_wd, input int pulse_k);
        int c0, lat, w, idle_at;
        c0  = cyc;
        lat = (i == 0) ? 1 : 3;
        w   = (sz == 2'b10) ? 1 : lat + 1;
        if (err) push(i, EV_ERR, 32'h0, 32'h0, c0 + 1);
        else begin
            push(i, EV_WR, {ad[31:2], 2'b00}, exp_wd, c0 + w);
            push(i, EV_DONE, 32'h0, 32'h0, c0 + w + 1);
        end
        drv(i, 1'b1, sz, ad, b);
        idle_at = -1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (pulse_k != 0 && cyc == c0 + pulse_k) drv(i, 1'b1, 2'b10, 32'h200, 32'hCAFEF00D);
            else                                     drv(i, 1'b0, 2'b11, 32'hFFFFFFFF, 32'h0);
            if (!bz_s[i]) begin
                idle_at = cyc - c0;
                break;
            end
        end
        cmp($sformatf("inst%0d busy_end", i), 128'(idle_at), 128'(err ? 2 : w + 2));
        drv(i, 1'b0, 2'b00, 32'h0, 32'h0);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 2'b00;
        drv(0, 1'b0, 2'b00, 32'h0, 32'h0);
        drv(1, 1'b0, 2'b00, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        cmp("rst_state_a", {ifa.mem_wr, ifa.busy, ifa.done, ifa.misaligned, ifa.mem_addr, ifa.mem_wdata}, '0);
        cmp("rst_state_b", {ifb.mem_wr, ifb.busy, ifb.done, ifb.misaligned, ifb.mem_addr, ifb.mem_wdata}, '0);
        rst_n = 2'b11;
        @(negedge clk);

        // Latency-1 instance: byte lanes, halfwords, word, extra start during DONE.
        store(0, 2'b00, 32'h102, 32'h12345678, 1'b0, 32'hAA78CCDD, 3);
        store(0, 2'b00, 32'h100, 32'h00000055, 1'b0, 32'hAABBCC55, 0);
        store(0, 2'b00, 32'h103, 32'h00000099, 1'b0, 32'h99BBCCDD, 0);
        store(0, 2'b01, 32'h102, 32'h12345678, 1'b0, 32'h5678CCDD, 0);
        store(0, 2'b01, 32'h100, 32'h12345678, 1'b0, 32'hAABB5678, 0);
        store(0, 2'b10, 32'h104, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 0);
        store(0, 2'b01, 32'h101, 32'h12345678, 1'b1, 32'h0, 0);
        store(0, 2'b10, 32'h106, 32'h12345678, 1'b1, 32'h0, 0);
        store(0, 2'b11, 32'h100, 32'h12345678, 1'b1, 32'h0, 0);

        // Latency-3 instance: ignored second start while reading.
        store(1, 2'b00, 32'h103, 32'h000000EE, 1'b0, 32'hEE223344, 2);

        // Reset during WRITE on the latency-1 instance: write strobe drops at once.
        drv(0, 1'b1, 2'b00, 32'h101, 32'h000000A5);
        @(negedge clk);
        drv(0, 1'b0, 2'b00, 32'h0, 32'h0);
        @(posedge clk); #1;
        cmp("wr_before_rst", 128'(ifa.mem_wr), 128'(1));
        rst_n[0] = 1'b0;
        #1;
        cmp("rst_abort_a", {ifa.mem_wr, ifa.busy, ifa.done, ifa.mem_addr, ifa.mem_wdata}, '0);
        @(negedge clk);
        rst_n[0] = 1'b1;
        @(negedge clk);
        store(0, 2'b00, 32'h101, 32'h000000A5, 1'b0, 32'hAABBA5DD, 0);

        // Reset during READ on the latency-3 instance.
        drv(1, 1'b1, 2'b00, 32'h101, 32'h00000077);
        @(negedge clk);
        drv(1, 1'b0, 2'b00, 32'h0, 32'h0);
        cmp("busy_in_read", 128'(ifb.busy), 128'(1));
        rst_n[1] = 1'b0;
        #1;
        cmp("rst_abort_b", {ifb.mem_wr, ifb.busy, ifb.done, ifb.mem_addr, ifb.mem_wdata}, '0);
        @(negedge clk);
        rst_n[1] = 1'b1;
        @(negedge clk);
        store(1, 2'b01, 32'h102, 32'h0000BEEF, 1'b0, 32'hBEEF3344, 0);

        repeat (3) @(negedge clk);
        cmp("q0_empty", 128'(q0.size()), 128'(0));
        cmp("q1_empty", 128'(q1.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
